// File: rtl/abdecoder.sv
// Recovers the highest active switch from a priority-encoder 7-segment display path.
// Inputs are synchronized, debounced for STABLE_CYCLES samples, decoded and handed off via valid/ready.
module abdecoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hex,
  input  logic       pointld,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] num,
  output logic [7:0] led,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

  localparam logic [8:0] IDLE_PAIR = 9'h002;
  localparam logic [3:0] CNT_LAST  = 4'(STABLE_CYCLES - 1);

  state_t     state, state_next;
  logic [8:0] s1, s2, cur, last_pair;
  logic [3:0] cnt;
  logic       dec_ok;
  logic [2:0] dec_num;
  logic [7:0] dec_led;
  logic       settle_done;

  assign settle_done = (state == SETTLE) && (s2 == cur) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (s2 != last_pair) state_next = SETTLE;
      SETTLE: if (settle_done) state_next = dec_ok ? EMIT : IDLE;
      EMIT:   if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode of the settled pair {pointld, hex}; feeds the registered outputs only.
  always_comb begin
    dec_ok  = 1'b0;
    dec_num = '0;
    dec_led = '0;
    if (cur[8]) begin
      dec_ok = 1'b1;
      case (cur[7:0])
        8'h02:   dec_num = 3'd0;
        8'h9F:   dec_num = 3'd1;
        8'h25:   dec_num = 3'd2;
        8'h0D:   dec_num = 3'd3;
        8'h99:   dec_num = 3'd4;
        8'h49:   dec_num = 3'd5;
        8'h41:   dec_num = 3'd6;
        8'h1F:   dec_num = 3'd7;
        default: dec_ok  = 1'b0;
      endcase
      if (dec_ok) dec_led = 8'd1 << dec_num;
    end else if (cur[7:0] == 8'h02) begin
      dec_ok = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= IDLE_PAIR;
      s2        <= IDLE_PAIR;
      cur       <= IDLE_PAIR;
      last_pair <= IDLE_PAIR;
      cnt       <= '0;
      out_valid <= 1'b0;
      num       <= '0;
      led       <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      s1  <= {pointld, hex};
      s2  <= s1;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s2 != last_pair) begin
            cur <= s2;
            cnt <= 4'd1;
          end
        end
        SETTLE: begin
          if (s2 != cur) begin
            cur <= s2;
            cnt <= 4'd1;
          end else if (cnt == CNT_LAST) begin
            // last_pair suppresses re-reporting until the input moves away and back.
            last_pair <= cur;
            if (dec_ok) begin
              out_valid <= 1'b1;
              num       <= dec_num;
              led       <= dec_led;
            end else begin
              err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abdecoder.sv
// Self-checking bench for abdecoder: directed scenarios plus randomized runs
// compared against a run-level reference model of the decoder.
module tb_abdecoder;

  localparam int S = 4;
  localparam logic [7:0] SEG [8] = '{8'h02, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hex = 8'h02;
  logic       pointld = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] num;
  logic [7:0] led;
  logic       err;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;

  logic        mon_en = 1'b0;
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

  abdecoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .hex(hex), .pointld(pointld), .out_ready(out_ready),
    .out_valid(out_valid), .num(num), .led(led), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Records accepted results {0,num,led} and error pulses {1,0,0}.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) got_q.push_back({1'b0, num, led});
      if (err) got_q.push_back({1'b1, 11'h0});
    end
  end

  // Reference: what a settled pair means, straight from the decode table.
  function automatic logic [11:0] ref_event(input logic [8:0] p);
    for (int k = 0; k < 8; k++)
      if (p[8] && p[7:0] == SEG[k]) return {1'b0, 3'(k), 8'(1 << k)};
    if (!p[8] && p[7:0] == 8'h02) return 12'h000;
    return {1'b1, 11'h0};
  endfunction

  task automatic drive(input logic p, input logic [7:0] h);
    pointld = p;
    hex     = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h02);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h02);
    repeat (2) @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (num !== 3'd0)       begin failures++; $display("FAIL reset_num got=%0d exp=0", num); end
    if (led !== 8'h00)      begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
    if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    if (err_cnt !== 8'd0)   begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_idle_hold();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cycle=%0d got valid=%b err=%b exp 0/0", i, out_valid, err);
      end
    end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive(1'b1, 8'h49);
    for (int i = 0; i <= S + 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i == S + 1)) begin
        failures++;
        $display("FAIL latency_valid edge=k+%0d got=%b exp=%b", i, out_valid, (i == S + 1));
      end
      if (i == S + 1) begin
        checks++;
        if (num !== 3'd5 || led !== 8'h20) begin
          failures++;
          $display("FAIL latency_data got num=%0d led=%h exp num=5 led=20", num, led);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int emits = 0;
    logic [2:0] n_seen = '0;
    logic [7:0] l_seen = '0;
    out_ready = 1'b1;
    drive(1'b1, 8'h0D);
    repeat (2) @(negedge clk);
    drive(1'b1, 8'h99);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        emits++;
        n_seen = num;
        l_seen = led;
      end
    end
    checks += 2;
    if (emits != 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", emits); end
    if (n_seen !== 3'd4 || l_seen !== 8'h10) begin
      failures++;
      $display("FAIL glitch_data got num=%0d led=%h exp num=4 led=10", n_seen, l_seen);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    out_ready = 1'b0;
    drive(1'b1, 8'h1F);
    wait_valid(20, found);
    checks += 2;
    if (!found) begin failures++; $display("FAIL bp_first_valid got=timeout exp=valid"); end
    if (num !== 3'd7 || led !== 8'h80) begin
      failures++;
      $display("FAIL bp_first_data got num=%0d led=%h exp num=7 led=80", num, led);
    end
    drive(1'b1, 8'h25);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || num !== 3'd7 || led !== 8'h80) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%b num=%0d led=%h exp v=1 num=7 led=80", i, out_valid, num, led);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
    wait_valid(20, found);
    checks += 2;
    if (!found) begin failures++; $display("FAIL bp_second_valid got=timeout exp=valid"); end
    if (num !== 3'd2 || led !== 8'h04) begin
      failures++;
      $display("FAIL bp_second_data got num=%0d led=%h exp num=2 led=04", num, led);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_second_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_error();
    int errs = 0;
    int valids = 0;
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'hFF);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (err) errs++;
      if (out_valid) valids++;
    end
    checks += 3;
    if (errs != 1)       begin failures++; $display("FAIL err_pulses got=%0d exp=1", errs); end
    if (valids != 0)     begin failures++; $display("FAIL err_valid got=%0d exp=0", valids); end
    if (err_cnt !== 8'd1) begin failures++; $display("FAIL err_cnt_one got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_saturation();
    int errs = 0;
    out_ready = 1'b1;
    for (int r = 0; r < 300; r++) begin
      drive(1'b1, 8'h99);
      repeat (S + 4) begin
        @(negedge clk);
        if (err) errs++;
      end
      drive(1'b1, 8'hFF);
      repeat (S + 4) begin
        @(negedge clk);
        if (err) errs++;
      end
    end
    checks += 2;
    if (errs != 300)        begin failures++; $display("FAIL sat_pulses got=%0d exp=300", errs); end
    if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); end
  endtask

  task automatic test_reset_during_emit();
    bit found;
    out_ready = 1'b0;
    drive(1'b1, 8'h41);
    wait_valid(20, found);
    checks++;
    if (!found) begin failures++; $display("FAIL rst_emit_valid got=timeout exp=valid"); end
    rst = 1'b1;
    drive(1'b0, 8'h02);
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_emit_out_valid got=%b exp=0", out_valid); end
    if (num !== 3'd0)       begin failures++; $display("FAIL rst_emit_num got=%0d exp=0", num); end
    if (led !== 8'h00)      begin failures++; $display("FAIL rst_emit_led got=%h exp=00", led); end
    if (err_cnt !== 8'd0)   begin failures++; $display("FAIL rst_emit_err_cnt got=%0d exp=0", err_cnt); end
    rst = 1'b0;
  endtask

  // Any run held long enough is reported once; runs shorter than S samples never are.
  task automatic test_random();
    logic [8:0] prev, p;
    int         kind, len, nerr;
    bit         long_run;
    do_reset();
    out_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    nerr = 0;
    prev = 9'h002;
    mon_en = 1'b1;
    for (int r = 0; r < 60; r++) begin
      do begin
        kind = $urandom_range(0, 9);
        if (kind < 8)       p = {1'b1, SEG[kind]};
        else if (kind == 8) p = 9'h002;
        else                p = 9'($urandom_range(0, 511));
      end while (p == prev);
      long_run = (r == 59) || ($urandom_range(0, 1) == 1);
      len = long_run ? $urandom_range(S + 4, S + 8) : $urandom_range(1, S - 1);
      if (long_run) begin
        exp_q.push_back(ref_event(p));
        if (ref_event(p) == {1'b1, 11'h0}) nerr++;
      end
      drive(p[8], p[7:0]);
      repeat (len) @(negedge clk);
      prev = p;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_event idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_cnt !== 8'((nerr > 255) ? 255 : nerr)) begin
      failures++;
      $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, nerr);
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_error();
    test_saturation();
    test_reset_during_emit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/abdecoder.md
ABDECODER -- requirements
Module: abdecoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required before decoding; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 hex  input  8  active-low 7-segment+point pattern from the priority-encoder display path; asynchronous to clk.
REQ-005 pointld  input  1  "any switch on" indicator paired with hex; asynchronous to clk.
REQ-006 out_ready  input  1  consumer accepts the current result when high with out_valid.
REQ-007 out_valid  output  1  result {num, led} valid.
REQ-008 num  output  3  decoded switch index.
REQ-009 led  output  8  one-hot reconstruction of the highest set switch; 0 means no switch.
REQ-010 err  output  1  one-cycle pulse on an undecodable stable input.
REQ-011 err_cnt  output  8  saturating count of err pulses.

Function
REQ-012 hex and pointld SHALL pass through a two-flop synchronizer (s1, s2) before any use.
REQ-013 Decode table (hex -> num), pointld=1: 0x02->0, 0x9F->1, 0x25->2, 0x0D->3, 0x99->4, 0x49->5, 0x41->6, 0x1F->7; led = 1<<num.
REQ-014 pointld=0 with hex=0x02 SHALL decode as "no switch": num=0, led=0x00, valid result.
REQ-015 Any other {pointld, hex} combination SHALL be an error: no out_valid, err pulses once, err_cnt increments.
REQ-016 FSM states: IDLE, SETTLE, EMIT.
REQ-017 IDLE: if s2 pair != last_pair, load cur=s2 pair, cnt=1, go SETTLE; else stay.
REQ-018 SETTLE: if s2 pair != cur, reload cur, cnt=1, stay; else if cnt==STABLE_CYCLES-1, decode cur, set last_pair=cur, go EMIT (valid) or IDLE with err pulse (error); else cnt+1.
REQ-019 EMIT: out_valid=1; num and led registered and held constant; on out_valid & out_ready go IDLE, out_valid low next cycle.
REQ-020 Inputs changing during EMIT SHALL NOT alter num/led; they are evaluated from IDLE after the handshake.
REQ-021 Latency: clean input step at edge k (captured into s1) -> out_valid high after edge k+STABLE_CYCLES+1 (k+5 at default).
REQ-022 err_cnt SHALL saturate at 255; err still pulses at saturation.
REQ-023 A stable erroneous pair SHALL report once; re-report only after the input moves to a different pair and back.
REQ-024 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-025 On rst high at an edge: state=IDLE, out_valid=0, num=0, led=0x00, err=0, err_cnt=0, cnt=0, s1/s2={0,0x02}, last_pair=cur={pointld=0, hex=0x02}.
REQ-026 rst SHALL override all other activity, including a pending EMIT handshake; result is discarded.
REQ-027 After reset, encoder-idle input {0, 0x02} SHALL produce no emission.

Verification
REQ-028 Reset, hold {0,0x02} 20 cycles -> out_valid=0, err=0 throughout.
REQ-029 {1,0x49}, out_ready=1 -> out_valid one cycle at k+5, num=5, led=0x20.
REQ-030 {1,0x0D} 2 cycles then {1,0x99} stable -> exactly one emission, num=4, led=0x10; none for 3.
REQ-031 {1,0x1F}, out_ready=0 10 cycles, input switched to {1,0x25} meanwhile -> num=7/led=0x80 held; after ready, second emission num=2, led=0x04.
REQ-032 {1,0xFF} held 30 cycles -> one err pulse, err_cnt=1, no out_valid; 300 alternating bad/good patterns -> err_cnt=255.
REQ-033 rst asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, num=0, led=0x00, err_cnt=0.
